// File: rtl/hfrv_sim_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : hfrv_sim_monitor
//  Purpose  : Bus-snooping byte-output channels with FIFOs, termination
//             register and cycle-timeout watchdog for hf-riscv simulation.
//  Revision : 1.0 - initial release
// ============================================================================
module hfrv_sim_monitor #(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter int                NUM_CH        = 2,
    parameter logic [ADDR_W-1:0] CH_BASE       = ADDR_W'(32'hf00000d0),
    parameter logic [ADDR_W-1:0] TERM_ADDR     = ADDR_W'(32'he0000000),
    parameter int                FIFO_DEPTH    = 16,
    parameter bit                BLOCK_ON_FULL = 1'b1,
    parameter int                CNT_W         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_valid,
    input  logic                bus_we,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic [DATA_W-1:0]   bus_wdata,
    output logic                stall_o,
    input  logic [NUM_CH-1:0]   ch_pop,
    output logic [8*NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic [NUM_CH-1:0]   ch_overflow,
    input  logic [CNT_W-1:0]    timeout_limit,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                terminated,
    output logic [1:0]          term_cause,
    output logic [DATA_W-1:0]   exit_code
);

    localparam int              c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0]  c_cnt_one  = (CNT_W+1)'(1);
    localparam logic [c_aw:0]   c_ptr_one  = (c_aw+1)'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                r_terminated;
    logic [1:0]          r_term_cause;
    logic [DATA_W-1:0]   r_exit_code;

    logic                w_wr_run;
    logic                w_term_hit;
    logic                w_timeout;
    logic [NUM_CH-1:0]   w_blocked;
    logic [NUM_CH-1:0]   w_valid;

    // Writes only count while running; gating on rst_n keeps stall_o low in reset.
    assign w_wr_run   = rst_n && bus_valid && bus_we && (r_state == S_RUN);
    assign w_term_hit = w_wr_run && (bus_addr == TERM_ADDR);
    assign w_timeout  = (timeout_limit != '0) &&
                        (({1'b0, r_cycle_count} + c_cnt_one) >= {1'b0, timeout_limit});

    assign stall_o    = BLOCK_ON_FULL && (|w_blocked);
    assign ch_valid   = w_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [ADDR_W-1:0] c_ch_addr = CH_BASE + ADDR_W'(4 * k);

        logic [7:0]   r_mem [FIFO_DEPTH];
        logic [c_aw:0] r_wr_ptr;
        logic [c_aw:0] r_rd_ptr;
        logic          r_ovf;
        logic          w_hit;
        logic          w_empty;
        logic          w_full;
        logic          w_pop;
        logic          w_push;

        assign w_hit   = w_wr_run && (bus_addr == c_ch_addr);
        assign w_empty = (r_wr_ptr == r_rd_ptr);
        assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                         (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
        assign w_pop   = ch_pop[k] && !w_empty;
        // A full FIFO still takes the byte when the head leaves in the same cycle.
        assign w_push  = w_hit && (!w_full || w_pop);
        assign w_blocked[k] = w_hit && w_full && !ch_pop[k];

        assign w_valid[k]          = !w_empty;
        assign ch_overflow[k]      = r_ovf;
        assign ch_data[8*k +: 8]   = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_aw-1:0]];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= bus_wdata[7:0];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (!BLOCK_ON_FULL && w_blocked[k]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_cycle_count <= '0;
            r_terminated  <= 1'b0;
            r_term_cause  <= 2'b00;
            r_exit_code   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cycle_count != {CNT_W{1'b1}}) begin
                        r_cycle_count <= r_cycle_count + CNT_W'(1);
                    end
                    // Software termination has priority over the watchdog.
                    if (w_term_hit) begin
                        r_exit_code  <= bus_wdata;
                        r_term_cause <= 2'b01;
                        r_state      <= S_DRAIN;
                    end else if (w_timeout) begin
                        r_exit_code  <= '0;
                        r_term_cause <= 2'b10;
                        r_state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!(|w_valid)) begin
                        r_state      <= S_DONE;
                        r_terminated <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_terminated <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign cycle_count = r_cycle_count;
    assign terminated  = r_terminated;
    assign term_cause  = r_term_cause;
    assign exit_code   = r_exit_code;

endmodule
`default_nettype wire

// File: tb/tb_hfrv_sim_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hfrv_sim_monitor
//  Purpose  : Runs a blocking and a dropping instance side by side against a
//             queue-based model, plus hand-computed directed checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hfrv_sim_monitor;

    localparam int          NCH       = 2;
    localparam int          DEPTH     = 16;
    localparam logic [31:0] CH_BASE   = 32'hf00000d0;
    localparam logic [31:0] TERM_ADDR = 32'he0000000;
    localparam int          M_RUN     = 0;
    localparam int          M_DRAIN   = 1;
    localparam int          M_DONE    = 2;

    logic        clk;
    logic        rst_n;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  ch_pop;
    logic [31:0] timeout_limit;

    // index 0: stalls on full, index 1: drops on full
    logic        stall       [2];
    logic [15:0] ch_data     [2];
    logic [1:0]  ch_valid    [2];
    logic [1:0]  ch_overflow [2];
    logic [31:0] cycle_count [2];
    logic        terminated  [2];
    logic [1:0]  term_cause  [2];
    logic [31:0] exit_code   [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int          m_st    [2];
    logic [31:0] m_cnt   [2];
    logic [31:0] m_exit  [2];
    logic        m_term  [2];
    logic [1:0]  m_cause [2];
    logic [1:0]  m_ovf   [2];
    logic [7:0]  mq      [4][$];

    hfrv_sim_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_CH(NCH), .CH_BASE(CH_BASE),
                       .TERM_ADDR(TERM_ADDR), .FIFO_DEPTH(DEPTH), .BLOCK_ON_FULL(1'b1),
                       .CNT_W(32)) u_blk (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .stall_o(stall[0]),
        .ch_pop(ch_pop), .ch_data(ch_data[0]), .ch_valid(ch_valid[0]),
        .ch_overflow(ch_overflow[0]), .timeout_limit(timeout_limit),
        .cycle_count(cycle_count[0]), .terminated(terminated[0]),
        .term_cause(term_cause[0]), .exit_code(exit_code[0])
    );

    hfrv_sim_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_CH(NCH), .CH_BASE(CH_BASE),
                       .TERM_ADDR(TERM_ADDR), .FIFO_DEPTH(DEPTH), .BLOCK_ON_FULL(1'b0),
                       .CNT_W(32)) u_drop (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .stall_o(stall[1]),
        .ch_pop(ch_pop), .ch_data(ch_data[1]), .ch_valid(ch_valid[1]),
        .ch_overflow(ch_overflow[1]), .timeout_limit(timeout_limit),
        .cycle_count(cycle_count[1]), .terminated(terminated[1]),
        .term_cause(term_cause[1]), .exit_code(exit_code[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Reference: per-channel byte queues and termination bookkeeping.
    always @(posedge clk) begin : model
        bit          all_empty;
        bit          wr_ok;
        bit          hit;
        bit          acc;
        bit          pop;
        int          q;
        logic [31:0] old;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_st[i] = M_RUN; m_cnt[i] = '0; m_exit[i] = '0;
                m_term[i] = 1'b0; m_cause[i] = 2'b00; m_ovf[i] = 2'b00;
                for (int c = 0; c < NCH; c++) mq[i*NCH+c].delete();
                chk_en = 1'b1;
            end else begin
                all_empty = 1'b1;
                for (int c = 0; c < NCH; c++)
                    if (mq[i*NCH+c].size() != 0) all_empty = 1'b0;
                wr_ok = bus_valid && bus_we && (m_st[i] == M_RUN);
                for (int c = 0; c < NCH; c++) begin
                    q   = i*NCH + c;
                    hit = wr_ok && (bus_addr == CH_BASE + 32'(4*c));
                    pop = ch_pop[c] && (mq[q].size() != 0);
                    acc = hit && ((mq[q].size() < DEPTH) || ch_pop[c]);
                    if (hit && !acc && i == 1) m_ovf[i][c] = 1'b1;
                    if (pop) void'(mq[q].pop_front());
                    if (acc) mq[q].push_back(bus_wdata[7:0]);
                end
                case (m_st[i])
                    M_RUN: begin
                        old = m_cnt[i];
                        if (old != 32'hffffffff) m_cnt[i] = old + 32'd1;
                        if (wr_ok && bus_addr == TERM_ADDR) begin
                            m_exit[i] = bus_wdata; m_cause[i] = 2'b01; m_st[i] = M_DRAIN;
                        end else if (timeout_limit != 0 &&
                                     longint'(old) + 1 >= longint'(timeout_limit)) begin
                            m_exit[i] = '0; m_cause[i] = 2'b10; m_st[i] = M_DRAIN;
                        end
                    end
                    M_DRAIN: if (all_empty) begin m_st[i] = M_DONE; m_term[i] = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_stall;
        int   q;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_stall = 1'b0;
                if (i == 0 && rst_n && bus_valid && bus_we && m_st[0] == M_RUN)
                    for (int c = 0; c < NCH; c++)
                        if (bus_addr == CH_BASE + 32'(4*c) && mq[c].size() == DEPTH && !ch_pop[c])
                            exp_stall = 1'b1;
                chk("stall_o", i, stall[i], exp_stall);
                for (int c = 0; c < NCH; c++) begin
                    q = i*NCH + c;
                    chk("ch_valid", i, ch_valid[i][c], mq[q].size() != 0);
                    if (mq[q].size() != 0) chk("ch_data", i, ch_data[i][8*c +: 8], mq[q][0]);
                    chk("ch_overflow", i, ch_overflow[i][c], m_ovf[i][c]);
                end
                chk("cycle_count", i, cycle_count[i], m_cnt[i]);
                chk("terminated", i, terminated[i], m_term[i]);
                chk("term_cause", i, term_cause[i], m_cause[i]);
                chk("exit_code", i, exit_code[i], m_exit[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus_valid = 1'b0; bus_we = 1'b0; ch_pop = 2'b00;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_valid = 1'b0; bus_we = 1'b0;
    endtask

    task automatic wait_term();
        for (int k = 0; k < 300 && !terminated[0]; k++) tick();
        chk("term_reached", 0, terminated[0], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        ch_pop = 2'b00; timeout_limit = '0;
        repeat (3) tick();

        // reset then idle: counter runs 1, 2, 3
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("count_after_reset", 0, cycle_count[0], 32'(i));
        end
        chk("idle_terminated", 0, terminated[0], 1'b0);
        chk("idle_cause", 0, term_cause[0], 2'b00);
        chk("idle_valid", 0, ch_valid[0], 2'b00);
        @(posedge clk); #1;

        // FIFO order on channel 0
        wr(CH_BASE, 32'h41); wr(CH_BASE, 32'h42); wr(CH_BASE, 32'h43);
        ch_pop = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("fifo_order", 0, ch_data[0][7:0], 8'h41 + 8'(i));
            @(posedge clk); #1;
        end
        ch_pop = 2'b00;
        @(negedge clk); chk("fifo_empty", 0, ch_valid[0][0], 1'b0);
        @(posedge clk); #1;

        // fill channel 1, then 17th write stalls until a pop releases it
        for (int i = 0; i < 16; i++) wr(CH_BASE + 32'd4, 32'h10 + 32'(i));
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = CH_BASE + 32'd4; bus_wdata = 32'h20;
        @(negedge clk);
        chk("stall_on_full", 0, stall[0], 1'b1);
        chk("no_stall_drop_mode", 1, stall[1], 1'b0);
        @(posedge clk); #1;
        ch_pop = 2'b10;
        @(negedge clk);
        chk("stall_released_by_pop", 0, stall[0], 1'b0);
        chk("head_before_release", 0, ch_data[0][15:8], 8'h10);
        chk("overflow_drop_mode", 1, ch_overflow[1][1], 1'b1);
        @(posedge clk); #1;
        bus_valid = 1'b0; bus_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("ch1_readback", 0, ch_data[0][15:8], 8'h11 + 8'(i));
            chk("ch1_readback", 1, ch_data[1][15:8], 8'h11 + 8'(i));
            @(posedge clk); #1;
        end
        ch_pop = 2'b00;
        @(negedge clk);
        chk("ch1_drained", 0, ch_valid[0][1], 1'b0);
        chk("overflow_block_mode", 0, ch_overflow[0], 2'b00);
        @(posedge clk); #1;

        // 17 writes to channel 0 with no pops: drop mode loses the last one
        for (int i = 0; i < 17; i++) wr(CH_BASE, 32'h50 + 32'(i));
        ch_pop = 2'b01;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("ch0_readback", 0, ch_data[0][7:0], 8'h50 + 8'(i));
            chk("ch0_readback", 1, ch_data[1][7:0], 8'h50 + 8'(i));
            @(posedge clk); #1;
        end
        ch_pop = 2'b00;
        @(negedge clk);
        chk("ch0_sixteen_only", 1, ch_valid[1][0], 1'b0);
        chk("overflow_sticky", 1, ch_overflow[1], 2'b11);
        @(posedge clk); #1;

        // software termination waits for the queued bytes to drain
        wr(CH_BASE, 32'h61); wr(CH_BASE, 32'h62); wr(CH_BASE, 32'h63);
        wr(TERM_ADDR, 32'h0000002a);
        wr(CH_BASE, 32'h99);
        wr(TERM_ADDR, 32'h55);
        @(negedge clk);
        chk("drain_not_term", 0, terminated[0], 1'b0);
        chk("first_term_final", 0, exit_code[0], 32'h2a);
        @(posedge clk); #1;
        ch_pop = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_data", 0, ch_data[0][7:0], 8'h61 + 8'(i));
            chk("drain_not_term", 0, terminated[0], 1'b0);
            @(posedge clk); #1;
        end
        ch_pop = 2'b00;
        @(negedge clk); chk("term_one_cycle_later", 0, terminated[0], 1'b0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("sw_terminated", i, terminated[i], 1'b1);
            chk("sw_cause", i, term_cause[i], 2'b01);
            chk("sw_exit", i, exit_code[i], 32'd42);
        end
        @(posedge clk); #1;

        // watchdog timeout at 100 cycles
        rst_n = 1'b0; timeout_limit = 32'd100;
        tick(); tick();
        rst_n = 1'b1;
        wait_term();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("to_count", i, cycle_count[i], 32'd100);
            chk("to_cause", i, term_cause[i], 2'b10);
            chk("to_exit", i, exit_code[i], 32'd0);
        end
        @(posedge clk); #1;

        // reset discards queued bytes; TERM on the limit cycle beats the timeout
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        wr(CH_BASE + 32'd4, 32'h77);
        rst_n = 1'b0;
        @(negedge clk); chk("queued_before_reset", 0, ch_valid[0][1], 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("reset_discards", 0, ch_valid[0], 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(99);
        @(negedge clk); chk("count_99", 0, cycle_count[0], 32'd99);
        #1;
        wr(TERM_ADDR, 32'd7);
        wait_term();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("tie_cause", i, term_cause[i], 2'b01);
            chk("tie_exit", i, exit_code[i], 32'd7);
            chk("tie_count", i, cycle_count[i], 32'd100);
        end
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
